regfile_mw_clr: RTL and testbench
=================================

// Module: regfile_mw_clr
// PURPOSE
// - Parametrised successor to the multi-ported register file: n_rd combinational read ports, two write ports.
// - Adds a hardware clear sequencer (on reset or CLR), optional write-to-read bypass, and sticky out-of-range error flags.
// - Used as the architectural/CSR-style storage inside bsc-generated cores where a known power-on state is needed without initial blocks.
// PARAMETERS
// - addr_width  5       width of every address port
// - data_width  32      width of every data port
// - lo          0       lowest valid index
// - hi          31      highest valid index; must satisfy lo <= hi < 2**addr_width
// - n_rd        4       number of read ports, 1..9
// - bypass      0       1: a read matching an enabled same-cycle write returns that write data
// - init_val    0       value written to every entry by the clear sequence (data_width bits)
// PORTS
// - CLK          in   1                     clock, all state updates on posedge
// - RST          in   1                     synchronous active-high reset
// - CLR          in   1                     pulse: restart the clear sequence (ignored while clearing)
// - WE_0         in   1                     write enable, port 0
// - ADDR_IN_0    in   addr_width            write address, port 0
// - D_IN_0       in   data_width            write data, port 0
// - WE_1         in   1                     write enable, port 1
// - ADDR_IN_1    in   addr_width            write address, port 1
// - D_IN_1       in   data_width            write data, port 1
// - ADDR_RD      in   n_rd*addr_width       packed read addresses, port k at [k*addr_width +: addr_width]
// - D_OUT_RD     out  n_rd*data_width       packed read data, port k at [k*data_width +: data_width]
// - RDY          out  1                     1 = array valid, writes accepted
// - ERR_RD       out  1                     sticky: an out-of-range read address was presented while RDY
// - ERR_WR       out  1                     sticky: a write was dropped (out of range, or WE while !RDY)
// BEHAVIOUR
// - FSM states CLEAR, READY. RST=1 at a posedge: state<=CLEAR, ptr<=lo, RDY<=0, ERR_RD<=0, ERR_WR<=0.
// - CLEAR: each cycle arr[ptr]<=init_val, ptr<=ptr+1; at ptr==hi write last entry, state<=READY.
//   Clear takes exactly hi-lo+1 cycles after RST deasserts; RDY=1 in the following cycle. ptr never wraps.
// - READY + CLR=1: state<=CLEAR, ptr<=lo, RDY<=0 next cycle; writes in that same cycle still commit.
// - RST mid-clear: sequence restarts from lo; RST has priority over CLR and over all writes.
// - Writes (READY only): WE_p with lo<=ADDR_IN_p<=hi commits D_IN_p at posedge, visible on reads next cycle.
//   Both ports same address: port 1 wins, no error. Out of range: write dropped, ERR_WR<=1.
//   WE_p while !RDY: write dropped, ERR_WR<=1 (clear data is never overwritten).
// - Reads: combinational, zero latency. While !RDY every D_OUT_RD slice = init_val.
//   Out-of-range address: slice = 0; ERR_RD<=1 only if RDY.
//   bypass=1: if RDY and an enabled in-range write matches, slice = that D_IN (port 1 if both match);
//   bypass=0: slice = stored value (old data in the write cycle).
// - ERR_RD/ERR_WR clear only on RST; CLR does not clear them.
// - Width rules: address compares unsigned, full addr_width; no truncation of data.
// TESTING
// - RST 1 cycle, lo=0 hi=31 -> RDY low 32 cycles, high on cycle 33; all 4 ports read init_val throughout.
// - READY, WE_0 addr 5 data 0xA5A5_0001 -> port0 reads 0xA5A5_0001 next cycle; same cycle shows old value (bypass=0), new value (bypass=1).
// - WE_0 and WE_1 both addr 7, data 0x11/0x22 -> arr[7]=0x22, ERR_WR stays 0.
// - lo=4 hi=11 addr_width 4: write addr 12 -> dropped, ERR_WR=1; read addr 2 -> slice 0, ERR_RD=1; both persist through CLR.
// - CLR after writing addr 3=0xFF -> RDY low 32 cycles, WE_1 during clear dropped with ERR_WR=1, addr 3 reads init_val after.
// - RST asserted at ptr=10 of clear -> sequence restarts at lo, RDY after a full 32 cycles, errors cleared.

Source files
------------

// File: rtl/regfile_mw_clr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mw_clr
// Purpose  : Parametrised register file with n_rd combinational read ports and
//            two write ports. A hardware clear sequencer loads init_val into
//            every entry after reset or a CLR pulse, so the array comes up in a
//            known state without initial blocks. It has an optional
//            write-to-read bypass and sticky out-of-range error flags.
// Ports    : CLK        clock, all state updates on posedge
//            RST        synchronous active-high reset
//            CLR        pulse, restarts the clear sequence (ignored while clearing)
//            WE_0/1     write enables
//            ADDR_IN_0/1, D_IN_0/1   write address / data
//            ADDR_RD    packed read addresses, port k at [k*addr_width +: addr_width]
//            D_OUT_RD   packed read data,      port k at [k*data_width +: data_width]
//            RDY        array valid, writes accepted
//            ERR_RD     sticky: out-of-range read address seen while RDY
//            ERR_WR     sticky: a write was dropped
// Revision : 1.0  initial release
// ============================================================================
module regfile_mw_clr #(
   parameter int                    addr_width = 5,
   parameter int                    data_width = 32,
   parameter int                    lo         = 0,
   parameter int                    hi         = 31,
   parameter int                    n_rd       = 4,
   parameter int                    bypass     = 0,
   parameter logic [data_width-1:0] init_val   = '0
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         CLR,
   input  logic                         WE_0,
   input  logic [addr_width-1:0]        ADDR_IN_0,
   input  logic [data_width-1:0]        D_IN_0,
   input  logic                         WE_1,
   input  logic [addr_width-1:0]        ADDR_IN_1,
   input  logic [data_width-1:0]        D_IN_1,
   input  logic [n_rd*addr_width-1:0]   ADDR_RD,
   output logic [n_rd*data_width-1:0]   D_OUT_RD,
   output logic                         RDY,
   output logic                         ERR_RD,
   output logic                         ERR_WR
);

   localparam logic [addr_width-1:0] C_LO     = addr_width'(lo);
   localparam logic [addr_width-1:0] C_HI     = addr_width'(hi);
   localparam bit                    C_BYPASS = (bypass != 0);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t                  r_state;
   logic [addr_width-1:0]   r_ptr;
   logic                    r_rdy;
   logic                    r_err_rd;
   logic                    r_err_wr;
   logic [data_width-1:0]   r_arr [lo:hi];

   logic                    w_in0;
   logic                    w_in1;
   logic                    w_wr_ok0;
   logic                    w_wr_ok1;
   logic                    w_wr_drop;
   logic [n_rd-1:0]         w_rd_oor;

   // Address is widened to int before comparing so the bounds test is a
   // plain value compare over the full address width.
   function automatic logic f_in_range(input logic [addr_width-1:0] a);
      int v;
      v = int'(a);
      return (v >= lo) && (v <= hi);
   endfunction

   assign w_in0     = f_in_range(ADDR_IN_0);
   assign w_in1     = f_in_range(ADDR_IN_1);
   assign w_wr_ok0  = WE_0 && r_rdy && w_in0;
   assign w_wr_ok1  = WE_1 && r_rdy && w_in1;
   assign w_wr_drop = (WE_0 && !(r_rdy && w_in0)) || (WE_1 && !(r_rdy && w_in1));

   // Control FSM and sticky flags
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= S_CLEAR;
         r_ptr    <= C_LO;
         r_rdy    <= 1'b0;
         r_err_rd <= 1'b0;
         r_err_wr <= 1'b0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               // ptr stops at hi; it never wraps past the last entry
               if (r_ptr == C_HI) begin
                  r_state <= S_READY;
                  r_rdy   <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
            S_READY: begin
               if (CLR) begin
                  r_state <= S_CLEAR;
                  r_ptr   <= C_LO;
                  r_rdy   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_CLEAR;
               r_ptr   <= C_LO;
               r_rdy   <= 1'b0;
            end
         endcase

         if (w_wr_drop) begin
            r_err_wr <= 1'b1;
         end
         if (r_rdy && (|w_rd_oor)) begin
            r_err_rd <= 1'b1;
         end
      end
   end

   // Storage: clear data while clearing, user writes while ready.
   // Port 1 is written last so it wins on an address collision.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (r_state == S_CLEAR) begin
            r_arr[r_ptr] <= init_val;
         end else begin
            if (w_wr_ok0) begin
               r_arr[ADDR_IN_0] <= D_IN_0;
            end
            if (w_wr_ok1) begin
               r_arr[ADDR_IN_1] <= D_IN_1;
            end
         end
      end
   end

   // Combinational read ports
   for (genvar k = 0; k < n_rd; k++) begin : g_rd
      logic [addr_width-1:0] w_addr;
      logic                  w_in;
      logic [data_width-1:0] w_data;

      assign w_addr      = ADDR_RD[k*addr_width +: addr_width];
      assign w_in        = f_in_range(w_addr);
      assign w_rd_oor[k] = !w_in;

      always_comb begin
         w_data = '0;
         if (!r_rdy) begin
            w_data = init_val;
         end else if (!w_in) begin
            w_data = '0;
         end else if (C_BYPASS && WE_1 && (ADDR_IN_1 == w_addr)) begin
            w_data = D_IN_1;
         end else if (C_BYPASS && WE_0 && (ADDR_IN_0 == w_addr)) begin
            w_data = D_IN_0;
         end else begin
            w_data = r_arr[w_addr];
         end
      end

      assign D_OUT_RD[k*data_width +: data_width] = w_data;
   end

   assign RDY    = r_rdy;
   assign ERR_RD = r_err_rd;
   assign ERR_WR = r_err_wr;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mw_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mw_clr
// Purpose  : Self-checking bench for regfile_mw_clr. Three instances:
//            u_dut0 defaults (bypass off), u_dut1 bypass on with a non-zero
//            init_val, u_dut2 narrow range lo=4 hi=11 addr_width=4.
//            Expected values are queued when stimulus is driven and popped
//            when the outputs are sampled.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mw_clr;

   localparam logic [31:0] C_INIT1 = 32'hDEAD_BEEF;

   logic          CLK = 1'b0;
   logic          RST;
   logic          CLR;
   logic          WE_0, WE_1;
   logic [4:0]    ADDR_IN_0, ADDR_IN_1;
   logic [31:0]   D_IN_0, D_IN_1;
   logic [19:0]   ADDR_RD;
   logic [127:0]  D_OUT_RD0, D_OUT_RD1;
   logic          RDY0, RDY1, ERR_RD0, ERR_RD1, ERR_WR0, ERR_WR1;

   logic          CLR2;
   logic          WE2_0, WE2_1;
   logic [3:0]    A2_0, A2_1;
   logic [31:0]   D2_0, D2_1;
   logic [7:0]    ADDR_RD2;
   logic [63:0]   D_OUT_RD2;
   logic          RDY2, ERR_RD2, ERR_WR2;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   always #5 CLK = ~CLK;

   regfile_mw_clr u_dut0 (
      .CLK(CLK), .RST(RST), .CLR(CLR),
      .WE_0(WE_0), .ADDR_IN_0(ADDR_IN_0), .D_IN_0(D_IN_0),
      .WE_1(WE_1), .ADDR_IN_1(ADDR_IN_1), .D_IN_1(D_IN_1),
      .ADDR_RD(ADDR_RD), .D_OUT_RD(D_OUT_RD0),
      .RDY(RDY0), .ERR_RD(ERR_RD0), .ERR_WR(ERR_WR0)
   );

   regfile_mw_clr #(.bypass(1), .init_val(C_INIT1)) u_dut1 (
      .CLK(CLK), .RST(RST), .CLR(CLR),
      .WE_0(WE_0), .ADDR_IN_0(ADDR_IN_0), .D_IN_0(D_IN_0),
      .WE_1(WE_1), .ADDR_IN_1(ADDR_IN_1), .D_IN_1(D_IN_1),
      .ADDR_RD(ADDR_RD), .D_OUT_RD(D_OUT_RD1),
      .RDY(RDY1), .ERR_RD(ERR_RD1), .ERR_WR(ERR_WR1)
   );

   regfile_mw_clr #(.addr_width(4), .lo(4), .hi(11), .n_rd(2)) u_dut2 (
      .CLK(CLK), .RST(RST), .CLR(CLR2),
      .WE_0(WE2_0), .ADDR_IN_0(A2_0), .D_IN_0(D2_0),
      .WE_1(WE2_1), .ADDR_IN_1(A2_1), .D_IN_1(D2_1),
      .ADDR_RD(ADDR_RD2), .D_OUT_RD(D_OUT_RD2),
      .RDY(RDY2), .ERR_RD(ERR_RD2), .ERR_WR(ERR_WR2)
   );

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: got %h expected <queued value>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   // inputs change 1 time unit after the posedge
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // count RDY-low cycles of u_dut0/u_dut1, checking reads hold init_val
   task automatic clear_window(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         expect_val({tag, "_rdy0"}, 32'd0);
         expect_val({tag, "_rdy1"}, 32'd0);
         expect_val({tag, "_rd0"}, 32'd0);
         expect_val({tag, "_rd1p3"}, C_INIT1);
         #2;
         chk({31'd0, RDY0});
         chk({31'd0, RDY1});
         chk(D_OUT_RD0[31:0]);
         chk(D_OUT_RD1[127:96]);
         step();
      end
   endtask

   initial begin
      RST = 1'b1; CLR = 1'b0;
      WE_0 = 1'b0; WE_1 = 1'b0; ADDR_IN_0 = '0; ADDR_IN_1 = '0;
      D_IN_0 = '0; D_IN_1 = '0;
      ADDR_RD = {5'd3, 5'd2, 5'd1, 5'd0};
      CLR2 = 1'b0; WE2_0 = 1'b0; WE2_1 = 1'b0; A2_0 = 4'd4; A2_1 = 4'd4;
      D2_0 = '0; D2_1 = '0;
      ADDR_RD2 = {4'd4, 4'd4};

      // ---- reset and power-on clear -------------------------------------
      step();
      RST = 1'b0;
      expect_val("rst_rdy", 32'd0);
      expect_val("rst_err_rd", 32'd0);
      expect_val("rst_err_wr", 32'd0);
      #1;
      chk({31'd0, RDY0});
      chk({31'd0, ERR_RD0});
      chk({31'd0, ERR_WR0});
      clear_window("pwr", 32);
      expect_val("pwr_rdy0_after", 32'd1);
      expect_val("pwr_rdy1_after", 32'd1);
      expect_val("pwr_rdy2_after", 32'd1);
      #2;
      chk({31'd0, RDY0});
      chk({31'd0, RDY1});
      chk({31'd0, RDY2});
      step();

      // ---- single write, bypass off vs on ------------------------------
      WE_0 = 1'b1; ADDR_IN_0 = 5'd5; D_IN_0 = 32'hA5A5_0001;
      ADDR_RD = {5'd3, 5'd2, 5'd1, 5'd5};
      expect_val("wr5_same_cyc_nobyp", 32'd0);
      expect_val("wr5_same_cyc_byp", 32'hA5A5_0001);
      #2;
      chk(D_OUT_RD0[31:0]);
      chk(D_OUT_RD1[31:0]);
      step();
      WE_0 = 1'b0;
      expect_val("wr5_next_nobyp", 32'hA5A5_0001);
      expect_val("wr5_next_byp", 32'hA5A5_0001);
      #2;
      chk(D_OUT_RD0[31:0]);
      chk(D_OUT_RD1[31:0]);
      step();

      // ---- both ports to the same address: port 1 wins -----------------
      WE_0 = 1'b1; ADDR_IN_0 = 5'd7; D_IN_0 = 32'h11;
      WE_1 = 1'b1; ADDR_IN_1 = 5'd7; D_IN_1 = 32'h22;
      ADDR_RD = {5'd3, 5'd2, 5'd7, 5'd5};
      expect_val("coll_byp_p1", 32'h22);
      expect_val("coll_nobyp_old", 32'd0);
      #2;
      chk(D_OUT_RD1[63:32]);
      chk(D_OUT_RD0[63:32]);
      step();
      WE_0 = 1'b0; WE_1 = 1'b0;
      expect_val("coll_arr7", 32'h22);
      expect_val("coll_err_wr", 32'd0);
      expect_val("coll_err_rd", 32'd0);
      expect_val("coll_keep5", 32'hA5A5_0001);
      #2;
      chk(D_OUT_RD0[63:32]);
      chk({31'd0, ERR_WR0});
      chk({31'd0, ERR_RD0});
      chk(D_OUT_RD0[31:0]);
      step();

      // ---- narrow-range instance: errors, and persistence through CLR ---
      WE2_0 = 1'b1; A2_0 = 4'd12; D2_0 = 32'h99;
      WE2_1 = 1'b1; A2_1 = 4'd5;  D2_1 = 32'h55;
      step();
      WE2_0 = 1'b0; WE2_1 = 1'b0;
      ADDR_RD2 = {4'd5, 4'd2};
      expect_val("d2_oor_wr_err", 32'd1);
      expect_val("d2_oor_rd_slice", 32'd0);
      expect_val("d2_inrange_wr", 32'h55);
      expect_val("d2_err_rd_pre", 32'd0);
      #2;
      chk({31'd0, ERR_WR2});
      chk(D_OUT_RD2[31:0]);
      chk(D_OUT_RD2[63:32]);
      chk({31'd0, ERR_RD2});
      step();
      ADDR_RD2 = {4'd5, 4'd4};
      expect_val("d2_err_rd_set", 32'd1);
      #2;
      chk({31'd0, ERR_RD2});
      step();
      CLR2 = 1'b1;
      step();
      CLR2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expect_val("d2_clr_rdy", 32'd0);
         #2;
         chk({31'd0, RDY2});
         step();
      end
      expect_val("d2_clr_rdy_after", 32'd1);
      expect_val("d2_clr_err_wr_kept", 32'd1);
      expect_val("d2_clr_err_rd_kept", 32'd1);
      expect_val("d2_clr_data_init", 32'd0);
      #2;
      chk({31'd0, RDY2});
      chk({31'd0, ERR_WR2});
      chk({31'd0, ERR_RD2});
      chk(D_OUT_RD2[63:32]);
      step();

      // ---- CLR of the wide instances, write during clear dropped -------
      WE_0 = 1'b1; ADDR_IN_0 = 5'd3; D_IN_0 = 32'hFF;
      ADDR_RD = {5'd3, 5'd2, 5'd7, 5'd3};
      step();
      WE_0 = 1'b0;
      expect_val("wr3_ff", 32'hFF);
      #2;
      chk(D_OUT_RD0[31:0]);
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      WE_1 = 1'b1; ADDR_IN_1 = 5'd3; D_IN_1 = 32'h77;
      step();
      WE_1 = 1'b0;
      clear_window("clr", 31);
      expect_val("clr_rdy_after", 32'd1);
      expect_val("clr_err_wr", 32'd1);
      expect_val("clr_addr3_init0", 32'd0);
      expect_val("clr_addr3_init1", C_INIT1);
      expect_val("clr_addr7_init0", 32'd0);
      #2;
      chk({31'd0, RDY0});
      chk({31'd0, ERR_WR0});
      chk(D_OUT_RD0[31:0]);
      chk(D_OUT_RD1[31:0]);
      chk(D_OUT_RD0[63:32]);
      step();

      // ---- RST in the middle of a clear sequence -----------------------
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      for (int i = 0; i < 10; i++) step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      expect_val("mid_err_wr0", 32'd0);
      expect_val("mid_err_wr2", 32'd0);
      expect_val("mid_err_rd2", 32'd0);
      #1;
      chk({31'd0, ERR_WR0});
      chk({31'd0, ERR_WR2});
      chk({31'd0, ERR_RD2});
      clear_window("mid", 32);
      expect_val("mid_rdy_after", 32'd1);
      expect_val("mid_err_wr0_after", 32'd0);
      #2;
      chk({31'd0, RDY0});
      chk({31'd0, ERR_WR0});
      step();

      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // safety net against a hung run
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
